i2c_reg_target: RTL
===================

# i2c_reg_target

I2C responder (target) that bridges bus transactions from `i2c_master` onto a simple byte-wide register-port interface. It watches SCL/SDA as open-drain inputs on the system clock, matches a 7-bit bus address, ACKs, and performs pointer-addressed writes and reads with auto-increment. It sits at the far end of the I2C wire from the master, with its register port feeding a local register bank or status block.

## Interface
- `DEV_ADDR`, 7'h2D: 7-bit bus address this target answers to.
- `SYNC_STAGES`, 2: synchronizer depth on SCL/SDA inputs, minimum 2.
- `clk`  in  1  system clock; must be at least 8× the SCL frequency.
- `reset`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  SCL line level; the target never stretches the clock.
- `sda_in`  in  1  SDA line level.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release the line (open-drain).
- `reg_addr`  out  8  register pointer presented to the bank.
- `reg_wdata`  out  8  write data, valid while `reg_we` = 1.
- `reg_we`  out  1  single-cycle write strobe.
- `reg_re`  out  1  single-cycle read strobe; the bank returns `reg_rdata` on the next `clk`.
- `reg_rdata`  in  8  read data from the bank.
- `busy`  out  1  high from an address match until STOP.

## Operation
- SCL and SDA pass through `SYNC_STAGES` flops. The block then derives `scl_rise`, `scl_fall`, `start` (SDA falls while SCL is high) and `stop` (SDA rises while SCL is high). Each is a one-cycle pulse.
- The block samples SDA on `scl_rise`. It changes `sda_oe` only on the cycle after `scl_fall`.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- **IDLE**: `start` moves to ADDR and clears the bit counter.
- **ADDR**: shifts 8 bits, MSB first.
  - If [7:1] equals `DEV_ADDR`: go to ADDR_ACK and set `busy`.
  - Otherwise: go to WAIT_STOP and leave SDA released (NACK).
- **ADDR_ACK**: drives `sda_oe` = 1 for one SCL low-high-low period.
  - R/W = 0: go to PTR.
  - R/W = 1: pulse `reg_re` at the ACK's `scl_fall`, load the shifter with `reg_rdata` one cycle later, and go to RDATA.
- **PTR**: shifts 8 bits into the pointer, ACKs through PTR_ACK, then goes to WDATA.
- **WDATA**: shifts 8 bits.
  - On the 8th `scl_rise`, pulses `reg_we` with `reg_addr` = pointer and `reg_wdata` = the byte.
  - In WDATA_ACK, the block ACKs and then increments the pointer.
- **RDATA**: drives `sda_oe` = ~bit, MSB first, updating on each `scl_fall`. After 8 bits it releases SDA and goes to RDATA_ACK.
- **RDATA_ACK**: samples the master's bit on `scl_rise`.
  - ACK (0): increment the pointer, pulse `reg_re`, load the shifter, and go to RDATA.
  - NACK (1): go to WAIT_STOP.
- **WAIT_STOP**: ignores all bits.
- Overrides:
  - `start` in any state goes to ADDR (repeated START).
  - `stop` in any state goes to IDLE, releases SDA and clears `busy`.
- Pointer behaviour:
  - 8 bits, wraps 8'hFF → 8'h00.
  - Retained across transactions, so the combined format (write pointer, repeated START, read) works.
  - Cleared only by reset.

## Timing
- Reset values: `sda_oe` = 0, `reg_we` = 0, `reg_re` = 0, `busy` = 0, `reg_addr` = 8'h00, `reg_wdata` = 8'h00, state = IDLE.
- `sda_oe` clears asynchronously on reset assertion, including mid-byte.
- Event latency: an SCL/SDA pin change becomes an event after `SYNC_STAGES` + 1 clk.
- `reg_we` and `reg_re` are exactly one `clk` wide. `reg_addr` is stable from the strobe until the next pointer change.
- Read data must be loaded at least 2 `clk` before the next `scl_rise`; the 8× clock-ratio requirement guarantees this.
- Simultaneous events: if `start` or `stop` coincides with `scl_rise` or `scl_fall`, `start`/`stop` wins.
- A STOP arriving mid-byte discards the partial byte: no write and no pointer change.

## Structure
- Package `i2c_pkg` holds:
  - the state enum;
  - constants `I2C_ACK` = 1'b0 and `I2C_NACK` = 1'b1;
  - the R/W bit encoding (0 = write).
- Sub-module `i2c_line_sync` contains the synchronizers plus the edge, START and STOP detection. It outputs the synced levels and the four event pulses.

## Test plan
- Write 0x5A, 0x07, 0xC3, STOP → ACK on all three bytes; one `reg_we` with `reg_addr` = 0x07 and `reg_wdata` = 0xC3; `busy` falls on STOP.
- Write 0x5A, 0x10, 0x11, 0x22, 0x33 → strobes at 0x10, 0x11, 0x12 with data 0x11, 0x22, 0x33.
- Write 0x5A, 0x20, repeated START, 0x5B; bank returns 0x96 then 0x3C; master ACKs then NACKs → SDA carries 0x96 then 0x3C; `reg_re` at 0x20 and 0x21; the target releases SDA after the NACK.
- Address 0x5C (0x2E, write) → no ACK (SDA stays released); no strobes; `busy` stays 0 through STOP.
- Pointer at 0xFF, two-byte write → writes go to 0xFF then 0x00.
- `reset` pulsed low during the 4th bit of a data byte → `sda_oe` = 0 immediately, no `reg_we`; the next transaction after reset completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus registered edge, START and STOP pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_pipe, sda_pipe;
  logic                   scl_d, sda_d;

  assign scl = scl_pipe[SYNC_STAGES-1];
  assign sda = sda_pipe[SYNC_STAGES-1];

  // Idle bus is high, so flops come out of reset high to avoid phantom events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl;
      sda_d    <= sda;
      scl_rise <= scl & ~scl_d;
      scl_fall <= ~scl & scl_d;
      start    <= scl & scl_d & sda_d & ~sda;
      stop     <= scl & scl_d & ~sda_d & sda;
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target bridging pointer-addressed bus reads/writes onto a byte register port.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h2D,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, sda_lvl, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .scl(scl_lvl), .sda(sda_lvl), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start(start), .stop(stop)
  );

  i2c_state_e state, state_nx;
  logic [2:0] bit_cnt, cnt_nx;
  logic [7:0] shreg, sh_nx, ptr, ptr_nx, wdata_nx, byte_in;
  logic       rw, rw_nx, ack_ph, ackph_nx, mack, mack_nx;
  logic       oe_nx, we_nx, re_nx, busy_nx;
  // [0] is the read strobe, [1] marks the cycle reg_rdata is valid
  logic [1:0] rd_pipe;

  assign reg_addr = ptr;
  assign reg_re   = rd_pipe[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_ph    <= 1'b0;
      mack      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      rd_pipe   <= '0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= cnt_nx;
      shreg     <= sh_nx;
      ptr       <= ptr_nx;
      rw        <= rw_nx;
      ack_ph    <= ackph_nx;
      mack      <= mack_nx;
      sda_oe    <= oe_nx;
      reg_we    <= we_nx;
      reg_wdata <= wdata_nx;
      busy      <= busy_nx;
      rd_pipe   <= {rd_pipe[0], re_nx};
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    sh_nx    = shreg;
    ptr_nx   = ptr;
    rw_nx    = rw;
    ackph_nx = ack_ph;
    mack_nx  = mack;
    oe_nx    = sda_oe;
    we_nx    = 1'b0;
    re_nx    = 1'b0;
    wdata_nx = reg_wdata;
    busy_nx  = busy;
    byte_in  = {shreg[6:0], sda_lvl};

    // First read bit goes out as soon as the bank answers, while SCL is still low.
    if (rd_pipe[1] && state == ST_RDATA && !scl_lvl) begin
      sh_nx = reg_rdata;
      oe_nx = ~reg_rdata[7];
    end

    if (stop) begin
      state_nx = ST_IDLE;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
      ackph_nx = 1'b0;
    end else if (start) begin
      state_nx = ST_ADDR;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
      ackph_nx = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            sh_nx  = byte_in;
            cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_nx = ST_ADDR_ACK;
                  rw_nx    = byte_in[0];
                  busy_nx  = 1'b1;
                end else begin
                  state_nx = ST_WAIT_STOP;
                end
              end else if (state == ST_PTR) begin
                ptr_nx   = byte_in;
                state_nx = ST_PTR_ACK;
              end else begin
                we_nx    = 1'b1;
                wdata_nx = byte_in;
                state_nx = ST_WDATA_ACK;
              end
            end
          end
        end
        // First fall drives the ACK, the fall after the 9th clock releases it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              oe_nx    = 1'b1;
              ackph_nx = 1'b1;
            end else begin
              oe_nx    = 1'b0;
              ackph_nx = 1'b0;
              cnt_nx   = '0;
              if (state == ST_PTR_ACK) begin
                state_nx = ST_WDATA;
              end else if (state == ST_WDATA_ACK) begin
                ptr_nx   = ptr + 8'd1;
                state_nx = ST_WDATA;
              end else if (rw == I2C_RW_READ) begin
                re_nx    = 1'b1;
                state_nx = ST_RDATA;
              end else begin
                state_nx = ST_PTR;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              oe_nx    = 1'b0;
              cnt_nx   = '0;
              mack_nx  = 1'b0;
              state_nx = ST_RDATA_ACK;
            end else begin
              oe_nx  = ~shreg[6];
              sh_nx  = {shreg[6:0], 1'b0};
              cnt_nx = bit_cnt + 3'd1;
            end
          end
        end
        // Next byte is fetched on the following fall so SDA only moves while SCL is low.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            mack_nx = (sda_lvl == I2C_ACK);
            if (sda_lvl == I2C_NACK) state_nx = ST_WAIT_STOP;
          end else if (scl_fall && mack) begin
            mack_nx  = 1'b0;
            ptr_nx   = ptr + 8'd1;
            re_nx    = 1'b1;
            state_nx = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
